// File: rtl/rr_mux_pkg.sv
// Shared constants, state encoding and round-robin pick helper for rr_mux_arbiter.
package rr_mux_pkg;

    localparam int NSRC = 4;
    localparam int SELW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] idx;
    } pick_t;

    // Search req starting at ptr, wrapping 3->0; the first set bit wins.
    // The loop runs from the farthest offset down so the nearest one is kept.
    function automatic pick_t rr_pick(input logic [NSRC-1:0] req,
                                      input logic [SELW-1:0] ptr);
        pick_t           r;
        logic [SELW-1:0] k;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            k = ptr + SELW'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_logic.sv
// Combinational rotate-and-priority-encode: winner index, found flag and one-hot.
module rr_pick_logic
    import rr_mux_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx,
    output logic [NSRC-1:0] onehot
);

    pick_t pick;

    // Resolve the winner starting the search at the priority pointer.
    always_comb begin
        pick = rr_pick(req, ptr);
    end

    assign found = pick.found;
    assign idx   = pick.idx;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_onehot
            assign onehot[gi] = pick.found && (pick.idx == SELW'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four sources feeding a single-entry valid/ready
// output buffer. Optional capture statistics are enabled by RR_GRANT_CNT_EN.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [NSRC-1:0]  gnt,
    output logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
`ifdef RR_GRANT_CNT_EN
    output logic [15:0]      gnt_cnt,
    output logic             last_src_repeat,
`endif
    input  logic             out_ready
);

    state_t           state_reg;
    logic [SELW-1:0]  ptr_reg;
    logic [SELW-1:0]  sel_reg;
    logic [WIDTH-1:0] out_reg;
    logic             valid_reg;

    logic             found;
    logic [SELW-1:0]  win;
    logic [NSRC-1:0]  win_oh;
    logic             cap;
    logic [WIDTH-1:0] win_data;

    rr_pick_logic u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .found  (found),
        .idx    (win),
        .onehot (win_oh)
    );

    // A word can be taken when the buffer is empty or is being drained now;
    // reset suppresses capture so gnt stays low while rst is high.
    assign cap = !rst && found && ((state_reg == EMPTY) || out_ready);
    assign gnt = cap ? win_oh : '0;

    // Data multiplexer driven by the current winner.
    always_comb begin
        win_data = a;
        case (win)
            2'd0:    win_data = a;
            2'd1:    win_data = b;
            2'd2:    win_data = c;
            default: win_data = d;
        endcase
    end

    // Buffer FSM, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (cap) begin
                        out_reg   <= win_data;
                        sel_reg   <= win;
                        valid_reg <= 1'b1;
                        ptr_reg   <= win + 2'd1;
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (cap) begin
                        out_reg   <= win_data;
                        sel_reg   <= win;
                        valid_reg <= 1'b1;
                        ptr_reg   <= win + 2'd1;
                    end else if (out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= EMPTY;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_reg;
    assign out       = out_reg;
    assign out_valid = valid_reg;

`ifdef RR_GRANT_CNT_EN
    logic [15:0] cnt_reg;
    logic        repeat_reg;
    logic        have_prev_reg;

    // Capture counter (wraps naturally) and same-source-as-last-capture flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            repeat_reg    <= 1'b0;
            have_prev_reg <= 1'b0;
        end else if (cap) begin
            cnt_reg       <= cnt_reg + 16'd1;
            repeat_reg    <= have_prev_reg && (win == sel_reg);
            have_prev_reg <= 1'b1;
        end
    end

    assign gnt_cnt         = cnt_reg;
    assign last_src_repeat = repeat_reg;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter: directed vector table plus randomized traffic
// checked against a behavioural round-robin model.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_w;
    logic             out_valid;
`ifdef RR_GRANT_CNT_EN
    logic [15:0]      gnt_cnt;
    logic             last_src_repeat;
`endif

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out_w),
        .out_valid (out_valid),
`ifdef RR_GRANT_CNT_EN
        .gnt_cnt         (gnt_cnt),
        .last_src_repeat (last_src_repeat),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic             r;
        logic [3:0]       rq;
        logic             rd;
        logic [WIDTH-1:0] da, db, dc, dd;
        logic [3:0]       eg;
        logic [WIDTH-1:0] eo;
        logic [1:0]       es;
        logic             ev;
    } vec_t;

    // Behavioural model state
    int               m_ptr;
    bit               m_full;
    logic [WIDTH-1:0] m_out;
    int               m_sel;

    // Drive one cycle, check gnt before the edge and registered outputs after it.
    task automatic apply(input vec_t v, input string tag);
        rst = v.r; req = v.rq; out_ready = v.rd;
        a = v.da; b = v.db; c = v.dc; d = v.dd;
        #2;
        vectors++;
        if (gnt !== v.eg) begin
            fails++;
            $display("FAIL %s gnt got %b want %b", tag, gnt, v.eg);
        end
        @(posedge clk);
        #1;
        if (out_w !== v.eo || sel !== v.es || out_valid !== v.ev) begin
            fails++;
            $display("FAIL %s out/sel/valid got %h/%0d/%b want %h/%0d/%b",
                     tag, out_w, sel, out_valid, v.eo, v.es, v.ev);
        end
        $display("vec %0d %s rst=%b req=%b rdy=%b gnt=%b out=%h sel=%0d v=%b",
                 vectors, tag, v.r, v.rq, v.rd, gnt, out_w, sel, out_valid);
    endtask

    // Compute expected outputs for one cycle from the arbitration rules.
    task automatic model_step(inout vec_t v);
        logic [WIDTH-1:0] data [4];
        int  w;
        bit  capture;
        data[0] = v.da; data[1] = v.db; data[2] = v.dc; data[3] = v.dd;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (w < 0 && v.rq[idx]) w = idx;
        end
        capture = !v.r && (w >= 0) && (!m_full || v.rd);
        v.eg = capture ? 4'(1 << w) : 4'b0000;
        if (v.r) begin
            m_ptr = 0; m_full = 0; m_out = '0; m_sel = 0;
        end else if (capture) begin
            m_out = data[w]; m_sel = w; m_full = 1; m_ptr = (w + 1) % 4;
        end else if (m_full && v.rd) begin
            m_full = 0;
        end
        v.eo = m_out;
        v.es = 2'(m_sel);
        v.ev = m_full;
    endtask

    vec_t tbl [32];
    int   ntbl;

    task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                       input logic [3:0] da, db, dc, dd,
                       input logic [3:0] eg, input logic [3:0] eo,
                       input logic [1:0] es, input logic ev);
        tbl[ntbl] = '{r, rq, rd, da, db, dc, dd, eg, eo, es, ev};
        ntbl++;
    endtask

    initial begin
        ntbl = 0;
        //   rst req    rdy a  b  c  d    gnt     out es ev
        // reset then idle
        add(1, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 0, 0, 0);
        add(1, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 0, 0, 0);
        // single capture of a
        add(0, 4'b0001, 1, 4, 2, 5, 6, 4'b0001, 4, 0, 1);
        add(0, 4'b0000, 1, 4, 2, 5, 6, 4'b0000, 4, 0, 0);
        // reset, then round-robin over all four
        add(1, 4'b0000, 1, 1, 2, 4, 6, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 2, 4, 6, 4'b0001, 1, 0, 1);
        add(0, 4'b1111, 1, 1, 2, 4, 6, 4'b0010, 2, 1, 1);
        add(0, 4'b1111, 1, 1, 2, 4, 6, 4'b0100, 4, 2, 1);
        add(0, 4'b1111, 1, 1, 2, 4, 6, 4'b1000, 6, 3, 1);
        add(0, 4'b1111, 1, 1, 2, 4, 6, 4'b0001, 1, 0, 1);
        add(0, 4'b0000, 1, 1, 2, 4, 6, 4'b0000, 1, 0, 0);
        // backpressure: b captured, then frozen, then c on ready
        add(0, 4'b0110, 0, 1, 2, 5, 6, 4'b0010, 2, 1, 1);
        add(0, 4'b0100, 0, 1, 2, 5, 6, 4'b0000, 2, 1, 1);
        add(0, 4'b0100, 0, 1, 2, 5, 6, 4'b0000, 2, 1, 1);
        add(0, 4'b0100, 1, 1, 2, 5, 6, 4'b0100, 5, 2, 1);
        add(0, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 5, 2, 0);
        // pointer wrap: d, then a before d
        add(0, 4'b1000, 1, 1, 2, 5, 6, 4'b1000, 6, 3, 1);
        add(0, 4'b1001, 1, 1, 2, 5, 6, 4'b0001, 1, 0, 1);
        add(0, 4'b1000, 1, 1, 2, 5, 6, 4'b1000, 6, 3, 1);
        add(0, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 6, 3, 0);
        // reset mid-operation under backpressure
        add(0, 4'b0100, 0, 1, 2, 5, 6, 4'b0100, 5, 2, 1);
        add(0, 4'b0000, 0, 1, 2, 5, 6, 4'b0000, 5, 2, 1);
        add(1, 4'b1111, 0, 1, 2, 5, 6, 4'b0000, 0, 0, 0);
        add(0, 4'b1010, 1, 1, 2, 5, 6, 4'b0010, 2, 1, 1);
        add(0, 4'b0000, 1, 1, 2, 5, 6, 4'b0000, 2, 1, 0);

        rst = 1; req = 0; out_ready = 0; a = 0; b = 0; c = 0; d = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < ntbl; i++) apply(tbl[i], "table");

        // randomized traffic against the model, starting from reset
        m_ptr = 0; m_full = 0; m_out = '0; m_sel = 0;
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.r  = (i == 0) || ($urandom_range(0, 39) == 0);
            v.rq = 4'($urandom_range(0, 15));
            v.rd = ($urandom_range(0, 3) != 0);
            v.da = 4'($urandom); v.db = 4'($urandom);
            v.dc = 4'($urandom); v.dd = 4'($urandom);
            model_step(v);
            apply(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
